// File: rtl/crack_scheduler.sv
// Keyspace scheduler: splits the key space into fixed-size chunks, hands them
// round-robin to the crack cores and reports the first key any core finds.
module crack_scheduler #(
  parameter int NCORES  = 2,
  parameter int KEY_W   = 24,
  parameter int CHUNK_W = 22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic                      rdy,
  output logic [KEY_W-1:0]          key,
  output logic                      key_valid,
  output logic [NCORES-1:0]         core_en,
  output logic [NCORES*KEY_W-1:0]   core_base,
  output logic [NCORES-1:0]         core_abort,
  input  logic [NCORES-1:0]         core_rdy,
  input  logic [NCORES-1:0]         core_found,
  input  logic [NCORES*KEY_W-1:0]   core_key
);

  localparam int NCW   = KEY_W - CHUNK_W + 1;
  localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [NCW-1:0] NCH = {1'b1, {(NCW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ABORT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [NCW-1:0]            next_chunk_q, next_chunk_d;
  logic [NCORES-1:0]         busy_q, busy_d;
  logic [NCORES-1:0]         started_q, started_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [KEY_W-1:0]          key_q, key_d;
  logic                      key_valid_q, key_valid_d;
  logic                      rdy_q, rdy_d;
  logic [NCORES-1:0]         core_en_q, core_en_d;
  logic [NCORES-1:0]         core_abort_q, core_abort_d;
  logic [NCORES*KEY_W-1:0]   core_base_q, core_base_d;

  logic [NCORES-1:0]         done_s;
  logic [NCORES-1:0]         found_s;
  logic [NCORES-1:0]         cand_s;
  logic                      pick_ok_s;
  logic [PTR_W-1:0]          pick_idx_s;
  logic [PTR_W-1:0]          rr_idx_s;
  logic [KEY_W-1:0]          found_key_s;

  // A core has completed once it was seen busy (rdy low) and rdy is back high.
  always_comb begin
    done_s  = busy_q & started_q & core_rdy;
    found_s = done_s & core_found;
    cand_s  = ~busy_q & core_rdy;
  end

  // Round-robin pick: descending scan so the first hit from ptr wins.
  always_comb begin
    pick_ok_s  = 1'b0;
    pick_idx_s = '0;
    rr_idx_s   = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      rr_idx_s = PTR_W'((int'(ptr_q) + k) % NCORES);
      if (cand_s[rr_idx_s]) begin
        pick_ok_s  = 1'b1;
        pick_idx_s = rr_idx_s;
      end else begin
        pick_ok_s  = pick_ok_s;
      end
    end
  end

  // Lowest-index finder wins a tie.
  always_comb begin
    found_key_s = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (found_s[i]) begin
        found_key_s = core_key[i*KEY_W +: KEY_W];
      end else begin
        found_key_s = found_key_s;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    next_chunk_d = next_chunk_q;
    ptr_d        = ptr_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    core_en_d    = '0;
    core_abort_d = '0;
    core_base_d  = core_base_q;
    started_d    = (started_q | (busy_q & ~core_rdy)) & ~done_s;
    busy_d       = busy_q & ~done_s;

    case (state_q)
      IDLE, DONE: begin
        if (en) begin
          state_d      = RUN;
          next_chunk_d = '0;
          busy_d       = '0;
          started_d    = '0;
          key_valid_d  = 1'b0;
          ptr_d        = '0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (|found_s) begin
          key_d        = found_key_s;
          key_valid_d  = 1'b1;
          core_abort_d = busy_d;
          state_d      = (|busy_d) ? ABORT : DONE;
        end else if (pick_ok_s && (next_chunk_q < NCH)) begin
          core_en_d[pick_idx_s] = 1'b1;
          busy_d[pick_idx_s]    = 1'b1;
          core_base_d[pick_idx_s*KEY_W +: KEY_W] = KEY_W'(next_chunk_q) << CHUNK_W;
          next_chunk_d = next_chunk_q + NCW'(1);
          ptr_d        = PTR_W'((int'(pick_idx_s) + 1) % NCORES);
        end else if ((next_chunk_q == NCH) && (busy_d == '0)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      ABORT: begin
        if (busy_d == '0) begin
          state_d = DONE;
        end else begin
          state_d = ABORT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      next_chunk_q <= '0;
      busy_q       <= '0;
      started_q    <= '0;
      ptr_q        <= '0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      rdy_q        <= 1'b1;
      core_en_q    <= '0;
      core_abort_q <= '0;
      core_base_q  <= '0;
    end else begin
      state_q      <= state_d;
      next_chunk_q <= next_chunk_d;
      busy_q       <= busy_d;
      started_q    <= started_d;
      ptr_q        <= ptr_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      rdy_q        <= rdy_d;
      core_en_q    <= core_en_d;
      core_abort_q <= core_abort_d;
      core_base_q  <= core_base_d;
    end
  end

  assign rdy        = rdy_q;
  assign key        = key_q;
  assign key_valid  = key_valid_q;
  assign core_en    = core_en_q;
  assign core_abort = core_abort_q;
  assign core_base  = core_base_q;

endmodule
